// File: rtl/pipelined_associative_data_array_if.sv
// Request/response bundle for the pipelined associative data array.
// The requester side uses the master modport, the array uses the slave modport.
interface pipelined_associative_data_array_if #(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int NUMBER_SETS                 = 64,
    parameter int NUMBER_WAYS                 = 16,
    parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
    parameter int BYTE_EN_WIDTH               = SINGLE_ELEMENT_SIZE_IN_BITS / 8
) ();
    logic                                               req_valid_in;
    logic                                               req_ready_out;
    logic                                               req_write_in;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]                   req_set_addr_in;
    logic [NUMBER_WAYS-1:0]                             req_way_select_in;
    logic [BYTE_EN_WIDTH-1:0]                           req_byte_en_in;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             req_write_data_in;
    logic                                               resp_valid_out;
    logic                                               resp_ready_in;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             resp_single_element_out;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0] resp_set_element_out;
    logic                                               way_select_error_out;

    modport master (
        output req_valid_in,
        input  req_ready_out,
        output req_write_in,
        output req_set_addr_in,
        output req_way_select_in,
        output req_byte_en_in,
        output req_write_data_in,
        input  resp_valid_out,
        output resp_ready_in,
        input  resp_single_element_out,
        input  resp_set_element_out,
        input  way_select_error_out
    );

    modport slave (
        input  req_valid_in,
        output req_ready_out,
        input  req_write_in,
        input  req_set_addr_in,
        input  req_way_select_in,
        input  req_byte_en_in,
        input  req_write_data_in,
        output resp_valid_out,
        input  resp_ready_in,
        output resp_single_element_out,
        output resp_set_element_out,
        output way_select_error_out
    );
endinterface

// File: rtl/pipelined_associative_data_array.sv
// Set-associative data array: one single-port RAM per way, shared set address.
// Reads return the whole set plus the way-selected element two cycles after
// accept; full writes complete in the accept cycle, partial writes go through
// a read-modify-write pair of states.
module pipelined_associative_data_array #(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int NUMBER_SETS                 = 64,
    parameter int NUMBER_WAYS                 = 16,
    parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
    parameter int BYTE_EN_WIDTH               = SINGLE_ELEMENT_SIZE_IN_BITS / 8
) (
    input logic                               clk_in,
    input logic                               reset_in,
    pipelined_associative_data_array_if.slave bus
);
    localparam int W = SINGLE_ELEMENT_SIZE_IN_BITS;
    localparam logic [NUMBER_WAYS-1:0] WAY_ONE = {{(NUMBER_WAYS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        RD_PEND,
        RESP,
        RMW_RD,
        RMW_WR
    } state_t;

    state_t state, state_next;

    function automatic logic is_one_hot(input logic [NUMBER_WAYS-1:0] sel);
        logic [NUMBER_WAYS-1:0] dec;
        dec = sel - WAY_ONE;
        return (sel != '0) && ((sel & dec) == '0);
    endfunction

    function automatic logic [W-1:0] merge_bytes(input logic [W-1:0]             old_d,
                                                 input logic [W-1:0]             new_d,
                                                 input logic [BYTE_EN_WIDTH-1:0] be);
        logic [W-1:0] m;
        m = old_d;
        for (int b = 0; b < BYTE_EN_WIDTH; b++) begin
            if (be[b]) m[b*8 +: 8] = new_d[b*8 +: 8];
        end
        return m;
    endfunction

    // Request fields held for RMW and for the read response select
    logic [SET_PTR_WIDTH_IN_BITS-1:0] set_p0;
    logic [NUMBER_WAYS-1:0]           way_p0;
    logic [BYTE_EN_WIDTH-1:0]         be_p0;
    logic [W-1:0]                     wdata_p0;
    logic                             sel_err_p0;

    // RAM port controls shared by every way
    logic                             rd_en;
    logic [NUMBER_WAYS-1:0]           wr_en;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] ram_addr;
    logic [W-1:0]                     ram_wdata;
    logic                             latch_en;

    logic [W*NUMBER_WAYS-1:0]         rd_flat_p1;
    logic [W-1:0]                     sel_data_p1;

    logic                             resp_vld_p2;
    logic [W-1:0]                     resp_single_p2;
    logic [W*NUMBER_WAYS-1:0]         resp_set_p2;
    logic                             sel_err_pulse;

    logic accept;
    logic sel_ok;
    logic be_full;
    logic be_none;

    assign accept  = bus.req_valid_in && (state == IDLE);
    assign sel_ok  = is_one_hot(bus.req_way_select_in);
    assign be_full = &bus.req_byte_en_in;
    assign be_none = ~|bus.req_byte_en_in;

    // ---- stage p1: per-way single-port RAMs with registered read data ----
    for (genvar g = 0; g < NUMBER_WAYS; g++) begin : g_way
        logic [W-1:0] mem [NUMBER_SETS];
        logic [W-1:0] rd_q_p1;

        // A way either writes or reads in a given cycle, never both.
        always_ff @(posedge clk_in) begin
            if (wr_en[g]) begin
                mem[ram_addr] <= ram_wdata;
            end else if (rd_en) begin
                rd_q_p1 <= mem[ram_addr];
            end
        end

        assign rd_flat_p1[g*W +: W] = rd_q_p1;
    end

    // Pick the element of the latched way out of the registered RAM outputs.
    always_comb begin
        sel_data_p1 = '0;
        for (int n = 0; n < NUMBER_WAYS; n++) begin
            if (way_p0[n]) sel_data_p1 = sel_data_p1 | rd_flat_p1[n*W +: W];
        end
    end

    // State register; reset aborts any read or RMW in flight.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and RAM port control.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        wr_en      = '0;
        ram_addr   = bus.req_set_addr_in;
        ram_wdata  = bus.req_write_data_in;
        latch_en   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    latch_en = 1'b1;
                    if (!bus.req_write_in) begin
                        rd_en      = 1'b1;
                        state_next = RD_PEND;
                    end else if (sel_ok && be_full) begin
                        wr_en = bus.req_way_select_in;
                    end else if (sel_ok && !be_none) begin
                        state_next = RMW_RD;
                    end
                end
            end
            RD_PEND: state_next = RESP;
            RESP: begin
                if (resp_vld_p2 && bus.resp_ready_in) state_next = IDLE;
            end
            RMW_RD: begin
                ram_addr   = set_p0;
                rd_en      = 1'b1;
                state_next = RMW_WR;
            end
            RMW_WR: begin
                ram_addr   = set_p0;
                ram_wdata  = merge_bytes(sel_data_p1, wdata_p0, be_p0);
                wr_en      = way_p0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- stage p0: capture request fields at accept ----
    always_ff @(posedge clk_in) begin
        if (latch_en) begin
            set_p0     <= bus.req_set_addr_in;
            way_p0     <= bus.req_way_select_in;
            be_p0      <= bus.req_byte_en_in;
            wdata_p0   <= bus.req_write_data_in;
            sel_err_p0 <= !sel_ok;
        end
    end

    // ---- stage p2: response registers, valid raised one cycle after capture ----
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            resp_vld_p2    <= 1'b0;
            resp_single_p2 <= '0;
            resp_set_p2    <= '0;
            sel_err_pulse  <= 1'b0;
        end else begin
            sel_err_pulse <= accept && !sel_ok;
            if (state == RD_PEND) begin
                resp_set_p2    <= rd_flat_p1;
                resp_single_p2 <= sel_err_p0 ? '0 : sel_data_p1;
            end
            if (state == RESP && !resp_vld_p2) begin
                resp_vld_p2 <= 1'b1;
            end else if (resp_vld_p2 && bus.resp_ready_in) begin
                resp_vld_p2 <= 1'b0;
            end
        end
    end

    assign bus.req_ready_out           = (state == IDLE);
    assign bus.resp_valid_out          = resp_vld_p2;
    assign bus.resp_single_element_out = resp_single_p2;
    assign bus.resp_set_element_out    = resp_set_p2;
    assign bus.way_select_error_out    = sel_err_pulse;
endmodule

// File: tb/tb_pipelined_associative_data_array.sv
// Self-checking bench for pipelined_associative_data_array with a
// per-way/per-set array model and randomized traffic.
module tb_pipelined_associative_data_array;
    localparam int W    = 64;
    localparam int SETS = 64;
    localparam int WAYS = 16;
    localparam int SPW  = 6;
    localparam int BEW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_associative_data_array_if #(
        .SINGLE_ELEMENT_SIZE_IN_BITS(W), .NUMBER_SETS(SETS), .NUMBER_WAYS(WAYS),
        .SET_PTR_WIDTH_IN_BITS(SPW), .BYTE_EN_WIDTH(BEW)
    ) bus ();

    pipelined_associative_data_array #(
        .SINGLE_ELEMENT_SIZE_IN_BITS(W), .NUMBER_SETS(SETS), .NUMBER_WAYS(WAYS),
        .SET_PTR_WIDTH_IN_BITS(SPW), .BYTE_EN_WIDTH(BEW)
    ) dut (
        .clk_in  (clk),
        .reset_in(rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mdl [WAYS][SETS];

    function automatic int way_idx(input logic [WAYS-1:0] way);
        if ($countones(way) != 1) return -1;
        for (int i = 0; i < WAYS; i++) if (way[i]) return i;
        return -1;
    endfunction

    function automatic void model_write(input int set, input logic [WAYS-1:0] way,
                                        input logic [BEW-1:0] be, input logic [W-1:0] d);
        int k;
        k = way_idx(way);
        if (k < 0) return;
        for (int b = 0; b < BEW; b++) if (be[b]) mdl[k][set][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic logic [W-1:0] model_single(input int set, input logic [WAYS-1:0] way);
        int k;
        k = way_idx(way);
        return (k < 0) ? '0 : mdl[k][set];
    endfunction

    function automatic logic [W*WAYS-1:0] model_row(input int set);
        logic [W*WAYS-1:0] r;
        for (int i = 0; i < WAYS; i++) r[i*W +: W] = mdl[i][set];
        return r;
    endfunction

    task automatic scramble();
        bus.req_write_in      = 1'($urandom);
        bus.req_set_addr_in   = SPW'($urandom);
        bus.req_way_select_in = WAYS'($urandom);
        bus.req_byte_en_in    = BEW'($urandom);
        bus.req_write_data_in = {$urandom, $urandom};
    endtask

    task automatic do_write(input int set, input logic [WAYS-1:0] way,
                            input logic [BEW-1:0] be, input logic [W-1:0] d);
        @(negedge clk);
        bus.req_valid_in      = 1'b1;
        bus.req_write_in      = 1'b1;
        bus.req_set_addr_in   = SPW'(set);
        bus.req_way_select_in = way;
        bus.req_byte_en_in    = be;
        bus.req_write_data_in = d;
        @(posedge clk);
        #1;
        bus.req_valid_in = 1'b0;
        scramble();
    endtask

    task automatic wait_idle(output int low);
        low = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.req_ready_out) break;
            low++;
        end
    endtask

    task automatic do_read(input int set, input logic [WAYS-1:0] way, output int lat,
                           output logic [W-1:0] single, output logic [W*WAYS-1:0] all,
                           output logic err0, output logic err1, output int low);
        @(negedge clk);
        bus.req_valid_in      = 1'b1;
        bus.req_write_in      = 1'b0;
        bus.req_set_addr_in   = SPW'(set);
        bus.req_way_select_in = way;
        bus.req_byte_en_in    = BEW'($urandom);
        @(posedge clk);
        #1;
        bus.req_valid_in = 1'b0;
        scramble();
        lat = -1; low = 0; err0 = 1'b0; err1 = 1'b0; single = 'x; all = 'x;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) err0 = bus.way_select_error_out;
            if (c == 1) err1 = bus.way_select_error_out;
            if (bus.resp_valid_out && lat < 0) begin
                lat    = c;
                single = bus.resp_single_element_out;
                all    = bus.resp_set_element_out;
            end
            if (bus.req_ready_out) break;
            low++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready_out !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b want=1", bus.req_ready_out);
        end
        checks++;
        if (bus.resp_valid_out !== 1'b0) begin
            failures++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid_out);
        end
        checks++;
        if (bus.way_select_error_out !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b want=0", bus.way_select_error_out);
        end
        checks++;
        if (bus.resp_single_element_out !== '0 || bus.resp_set_element_out !== '0) begin
            failures++; $display("FAIL reset_resp_data got=%h want=0", bus.resp_single_element_out);
        end
    endtask

    task automatic test_fill();
        int stalls = 0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                logic [W-1:0] d;
                d = {$urandom, $urandom};
                @(negedge clk);
                if (!bus.req_ready_out) stalls++;
                bus.req_valid_in      = 1'b1;
                bus.req_write_in      = 1'b1;
                bus.req_set_addr_in   = SPW'(s);
                bus.req_way_select_in = WAYS'(1) << w;
                bus.req_byte_en_in    = '1;
                bus.req_write_data_in = d;
                model_write(s, WAYS'(1) << w, '1, d);
            end
        end
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        checks++;
        if (stalls !== 0) begin
            failures++; $display("FAIL fill_stalls got=%0d want=0", stalls);
        end
    endtask

    task automatic test_basic();
        int lat, low; logic [W-1:0] s; logic [W*WAYS-1:0] a; logic e0, e1;
        do_write(5, 16'h0008, 8'hFF, 64'h1122334455667788);
        model_write(5, 16'h0008, 8'hFF, 64'h1122334455667788);
        wait_idle(low);
        checks++;
        if (low !== 0) begin failures++; $display("FAIL full_write_busy got=%0d want=0", low); end
        do_read(5, 16'h0008, lat, s, a, e0, e1, low);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL read_latency got=%0d want=2", lat); end
        checks++;
        if (s !== 64'h1122334455667788) begin
            failures++; $display("FAIL read_single got=%h want=1122334455667788", s);
        end
        checks++;
        if (low !== 3) begin failures++; $display("FAIL read_busy got=%0d want=3", low); end
        checks++;
        if (a !== model_row(5)) begin failures++; $display("FAIL read_set got=%h want=%h", a, model_row(5)); end
    endtask

    task automatic test_partial();
        int lat, low; logic [W-1:0] s; logic [W*WAYS-1:0] a; logic e0, e1;
        do_write(5, 16'h0008, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        model_write(5, 16'h0008, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        wait_idle(low);
        checks++;
        if (low !== 2) begin failures++; $display("FAIL rmw_busy got=%0d want=2", low); end
        do_read(5, 16'h0008, lat, s, a, e0, e1, low);
        checks++;
        if (s !== 64'h11223344AAAAAAAA) begin
            failures++; $display("FAIL rmw_merge got=%h want=11223344AAAAAAAA", s);
        end
    endtask

    task automatic test_backpressure();
        int lat, low, seen; logic [W-1:0] s, s2; logic [W*WAYS-1:0] a, a2; logic e0, e1;
        bus.resp_ready_in = 1'b0;
        @(negedge clk);
        bus.req_valid_in = 1'b1; bus.req_write_in = 1'b0;
        bus.req_set_addr_in = SPW'(9); bus.req_way_select_in = 16'h0100;
        @(posedge clk);
        #1 bus.req_valid_in = 1'b0;
        seen = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.resp_valid_out) begin seen = c; break; end
        end
        checks++;
        if (seen !== 2) begin failures++; $display("FAIL bp_latency got=%0d want=2", seen); end
        s = bus.resp_single_element_out;
        a = bus.resp_set_element_out;
        checks++;
        if (s !== model_single(9, 16'h0100)) begin
            failures++; $display("FAIL bp_data got=%h want=%h", s, model_single(9, 16'h0100));
        end
        bus.req_valid_in = 1'b1; bus.req_write_in = 1'b1;
        bus.req_set_addr_in = SPW'(9); bus.req_way_select_in = 16'h0100;
        bus.req_byte_en_in = 8'hFF; bus.req_write_data_in = ~s;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.resp_valid_out, bus.req_ready_out, bus.resp_single_element_out} !== {1'b1, 1'b0, s}
                || bus.resp_set_element_out !== a) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                         i, bus.resp_valid_out, bus.req_ready_out, bus.resp_single_element_out, s);
            end
        end
        bus.req_valid_in  = 1'b0;
        bus.resp_ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.resp_valid_out, bus.req_ready_out} !== 2'b01) begin
            failures++; $display("FAIL bp_release valid=%b ready=%b want valid=0 ready=1",
                                 bus.resp_valid_out, bus.req_ready_out);
        end
        do_read(9, 16'h0100, lat, s2, a2, e0, e1, low);
        checks++;
        if (s2 !== model_single(9, 16'h0100)) begin
            failures++; $display("FAIL bp_no_write got=%h want=%h", s2, model_single(9, 16'h0100));
        end
    endtask

    task automatic test_way_error();
        int lat, low, set; logic [W-1:0] s; logic [W*WAYS-1:0] a; logic e0, e1;
        set = $urandom_range(SETS-1);
        do_read(set, 16'h0005, lat, s, a, e0, e1, low);
        checks++;
        if ({e0, e1} !== 2'b10) begin failures++; $display("FAIL err_pulse got=%b%b want=10", e0, e1); end
        checks++;
        if (s !== '0) begin failures++; $display("FAIL err_single got=%h want=0", s); end
        checks++;
        if (a !== model_row(set) || lat !== 2) begin
            failures++; $display("FAIL err_set lat=%0d got=%h want=%h", lat, a, model_row(set));
        end
        do_write(set, 16'h0005, 8'hFF, {$urandom, $urandom});
        wait_idle(low);
        checks++;
        if (low !== 0) begin failures++; $display("FAIL err_write_busy got=%0d want=0", low); end
        do_write(set, 16'h0000, 8'h0F, {$urandom, $urandom});
        wait_idle(low);
        checks++;
        if (low !== 0) begin failures++; $display("FAIL err_zero_busy got=%0d want=0", low); end
        do_read(set, 16'h0001, lat, s, a, e0, e1, low);
        checks++;
        if (a !== model_row(set)) begin failures++; $display("FAIL err_no_change got=%h want=%h", a, model_row(set)); end
    endtask

    task automatic test_zero_be();
        int lat, low, set; logic [W-1:0] s; logic [W*WAYS-1:0] a; logic e0, e1;
        logic [WAYS-1:0] way;
        set = $urandom_range(SETS-1);
        way = WAYS'(1) << $urandom_range(WAYS-1);
        do_write(set, way, 8'h00, {$urandom, $urandom});
        model_write(set, way, 8'h00, '0);
        wait_idle(low);
        checks++;
        if (low !== 0) begin failures++; $display("FAIL zero_be_busy got=%0d want=0", low); end
        do_read(set, way, lat, s, a, e0, e1, low);
        checks++;
        if (s !== model_single(set, way)) begin
            failures++; $display("FAIL zero_be_data got=%h want=%h", s, model_single(set, way));
        end
    endtask

    task automatic test_back_to_back();
        int lat, low, acc; logic [W-1:0] s; logic [W*WAYS-1:0] a, expv; logic e0, e1;
        acc = 0;
        for (int i = 0; i < WAYS; i++) begin
            @(negedge clk);
            if (bus.req_ready_out) acc++;
            bus.req_valid_in = 1'b1; bus.req_write_in = 1'b1;
            bus.req_set_addr_in = '0; bus.req_way_select_in = WAYS'(1) << i;
            bus.req_byte_en_in = '1; bus.req_write_data_in = W'(i);
            model_write(0, WAYS'(1) << i, '1, W'(i));
            expv[i*W +: W] = W'(i);
        end
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        checks++;
        if (acc !== 16 || !bus.req_ready_out) begin
            failures++; $display("FAIL b2b_accepts got=%0d want=16", acc);
        end
        do_read(0, 16'h0001, lat, s, a, e0, e1, low);
        checks++;
        if (a !== expv) begin failures++; $display("FAIL b2b_set got=%h want=%h", a, expv); end
    endtask

    task automatic test_forward();
        int lat, low, set; logic [W-1:0] s, d; logic [W*WAYS-1:0] a; logic e0, e1;
        logic [WAYS-1:0] way;
        for (int k = 0; k < 8; k++) begin
            set = $urandom_range(SETS-1);
            way = WAYS'(1) << $urandom_range(WAYS-1);
            d   = {$urandom, $urandom};
            do_write(set, way, '1, d);
            model_write(set, way, '1, d);
            do_read(set, way, lat, s, a, e0, e1, low);
            checks++;
            if (s !== d) begin failures++; $display("FAIL forward k=%0d got=%h want=%h", k, s, d); end
        end
    endtask

    task automatic test_rmw_reset();
        int lat, low, seen; logic [W-1:0] s, old; logic [W*WAYS-1:0] a; logic e0, e1;
        old = model_single(12, 16'h0400);
        do_write(12, 16'h0400, 8'h3C, ~old);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready_out, bus.resp_valid_out} !== 2'b10) begin
            failures++; $display("FAIL rmw_reset ready=%b valid=%b want ready=1 valid=0",
                                 bus.req_ready_out, bus.resp_valid_out);
        end
        @(negedge clk);
        rst = 1'b0;
        do_read(12, 16'h0400, lat, s, a, e0, e1, low);
        checks++;
        if (s !== old) begin failures++; $display("FAIL rmw_abort got=%h want=%h", s, old); end
        bus.resp_ready_in = 1'b0;
        @(negedge clk);
        bus.req_valid_in = 1'b1; bus.req_write_in = 1'b0;
        bus.req_set_addr_in = SPW'(12); bus.req_way_select_in = 16'h0400;
        @(posedge clk);
        #1 bus.req_valid_in = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.resp_valid_out) begin seen = 1; break; end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (seen !== 1 || bus.resp_valid_out !== 1'b0 || bus.resp_single_element_out !== '0) begin
            failures++; $display("FAIL resp_reset seen=%0d valid=%b data=%h want valid=0 data=0",
                                 seen, bus.resp_valid_out, bus.resp_single_element_out);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.resp_ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready_out, bus.resp_valid_out} !== 2'b10) begin
            failures++; $display("FAIL resp_reset_idle ready=%b valid=%b", bus.req_ready_out, bus.resp_valid_out);
        end
    endtask

    task automatic test_random();
        int lat, low, set, want_low; logic [W-1:0] s, d; logic [W*WAYS-1:0] a; logic e0, e1;
        logic [WAYS-1:0] way; logic [BEW-1:0] be; int r;
        for (int k = 0; k < 150; k++) begin
            set = $urandom_range(SETS-1);
            if ($urandom_range(9) == 0) way = WAYS'($urandom);
            else                        way = WAYS'(1) << $urandom_range(WAYS-1);
            if ($urandom_range(1) == 0) begin
                do_read(set, way, lat, s, a, e0, e1, low);
                checks++;
                if (lat !== 2 || s !== model_single(set, way) || a !== model_row(set)
                    || e0 !== ($countones(way) != 1)) begin
                    failures++;
                    $display("FAIL rand_read k=%0d lat=%0d err=%b got=%h want=%h",
                             k, lat, e0, s, model_single(set, way));
                end
            end else begin
                r = $urandom_range(9);
                if (r < 4)       be = '1;
                else if (r < 8)  be = BEW'($urandom);
                else if (r == 8) be = '0;
                else             be = BEW'(1) << $urandom_range(BEW-1);
                d = {$urandom, $urandom};
                do_write(set, way, be, d);
                model_write(set, way, be, d);
                want_low = ($countones(way) == 1 && be != '0 && be != '1) ? 2 : 0;
                wait_idle(low);
                checks++;
                if (low !== want_low) begin
                    failures++; $display("FAIL rand_write_busy k=%0d got=%0d want=%0d", k, low, want_low);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid_in      = 1'b0;
        bus.req_write_in      = 1'b0;
        bus.req_set_addr_in   = '0;
        bus.req_way_select_in = '0;
        bus.req_byte_en_in    = '0;
        bus.req_write_data_in = '0;
        bus.resp_ready_in     = 1'b1;
        test_reset();
        test_fill();
        test_basic();
        test_partial();
        test_backpressure();
        test_way_error();
        test_zero_be();
        test_back_to_back();
        test_forward();
        test_rmw_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
